motion_estimator: RTL and testbench

- Full-search block-matching motion estimator. Compares one 8x8 current block with every 8x8 candidate in a 32x32 reference search window and reports the minimum SAD and its offset.
- Sits between two sequential-read memory streamers (current-frame and reference-frame) that return one word per read strobe.
- Processes blocks back-to-back while enabled.

---
 rtl/motion_estimator_pkg.sv | 25 ++
 rtl/motion_estimator_if.sv | 27 ++
 rtl/motion_estimator_sad_8x8.sv | 29 ++
 rtl/motion_estimator.sv | 150 +++++++++++++++
 tb/tb_motion_estimator.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/motion_estimator_pkg.sv
// Shared constants and state type for the full-search block-matching motion estimator.
package me_pkg;
  localparam int PIX_W      = 8;
  localparam int BLK        = 8;
  localparam int WIN        = 32;
  localparam int NUM_OFF    = WIN - BLK + 1;
  localparam int CUR_WORDS  = 16;
  localparam int REF_WORDS  = 128;
  localparam int SAD_W      = 14;
  localparam int CUR_WORD_W = 4 * PIX_W;
  localparam int REF_WORD_W = 8 * PIX_W;

  // LOAD-phase cycle markers, relative to the first LOAD cycle.
  localparam logic [7:0] CUR_LAST_STROBE = 8'(CUR_WORDS - 1);
  localparam logic [7:0] REF_LAST_STROBE = 8'(CUR_WORDS + REF_WORDS - 1);
  localparam logic [7:0] LOAD_LAST       = 8'(CUR_WORDS + REF_WORDS);
  localparam logic [4:0] OFF_LAST        = 5'(NUM_OFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } me_state_e;
endpackage

// File: rtl/motion_estimator_if.sv
// Streamer and result bus of the motion estimator; slave = estimator, master = environment.
interface me_if;
  import me_pkg::*;

  // A read strobe in cycle N means the streamer presents the next word in cycle N+1;
  // there is no ready/back-pressure, and data_valid is a single-cycle result strobe.
  logic                  en_i;
  logic [CUR_WORD_W-1:0] cur_in_i;
  logic [REF_WORD_W-1:0] ref_in_i;
  logic                  cur_read_en;
  logic                  ref_read_en;
  logic [SAD_W-1:0]      MSAD;
  logic [4:0]            MSAD_row;
  logic [4:0]            MSAD_column;
  logic                  data_valid;
  me_state_e             dbg_state;

  modport slave (
    input  en_i, cur_in_i, ref_in_i,
    output cur_read_en, ref_read_en, MSAD, MSAD_row, MSAD_column, data_valid, dbg_state
  );

  modport master (
    output en_i, cur_in_i, ref_in_i,
    input  cur_read_en, ref_read_en, MSAD, MSAD_row, MSAD_column, data_valid, dbg_state
  );
endinterface

// File: rtl/motion_estimator_sad_8x8.sv
// Single-cycle sum of absolute differences over an 8x8 pixel pair, row sums then total.
module sad_8x8
  import me_pkg::*;
(
  input  logic [BLK*BLK*PIX_W-1:0] cur_pix_i,
  input  logic [BLK*BLK*PIX_W-1:0] ref_pix_i,
  output logic [SAD_W-1:0]         sad_o
);

  always_comb begin
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic [PIX_W+2:0] row_sum;
    sad_o   = '0;
    a       = '0;
    b       = '0;
    row_sum = '0;
    for (int r = 0; r < BLK; r++) begin
      row_sum = '0;
      for (int c = 0; c < BLK; c++) begin
        a = cur_pix_i[(r*BLK + c)*PIX_W +: PIX_W];
        b = ref_pix_i[(r*BLK + c)*PIX_W +: PIX_W];
        row_sum = row_sum + {3'b000, ((a > b) ? (a - b) : (b - a))};
      end
      sad_o = sad_o + {{(SAD_W-PIX_W-3){1'b0}}, row_sum};
    end
  end

endmodule

// File: rtl/motion_estimator.sv
// Full-search motion estimator: loads an 8x8 block and a 32x32 window, scans 25x25 offsets.
module motion_estimator
  import me_pkg::*;
(
  input  logic clk,
  input  logic rst,
  me_if.slave  bus
);

  me_state_e        state_q;
  logic [7:0]       cnt_q;
  logic [4:0]       row_q, col_q;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [4:0]       best_row_q, best_row_d, best_col_q, best_col_d;
  logic             cur_rd_q, ref_rd_q, valid_q;
  logic [SAD_W-1:0] msad_q;
  logic [4:0]       msad_row_q, msad_col_q;

  logic [CUR_WORD_W-1:0] cur_buf [CUR_WORDS];
  logic [REF_WORD_W-1:0] ref_buf [REF_WORDS];
  logic [3:0]            cur_idx;
  logic [6:0]            ref_idx;

  logic [BLK*BLK*PIX_W-1:0] cur_blk, ref_blk;
  logic [SAD_W-1:0]         sad;
  logic                     last_cand;

  // Word fetched by the strobe of LOAD cycle k is on the bus in cycle k+1.
  assign cur_idx = 4'(cnt_q - 8'd1);
  assign ref_idx = 7'(cnt_q - 8'(CUR_WORDS + 1));

  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      if (cnt_q != 8'd0 && cnt_q <= 8'(CUR_WORDS)) cur_buf[cur_idx] <= bus.cur_in_i;
      if (cnt_q > 8'(CUR_WORDS))                   ref_buf[ref_idx] <= bus.ref_in_i;
    end
  end

  always_comb begin
    cur_blk = '0;
    for (int i = 0; i < CUR_WORDS; i++) cur_blk[i*CUR_WORD_W +: CUR_WORD_W] = cur_buf[i];
  end

  // Each candidate row is a 256-bit window row shifted right by the column offset.
  always_comb begin
    logic [WIN*PIX_W-1:0] win_row;
    ref_blk = '0;
    win_row = '0;
    for (int r = 0; r < BLK; r++) begin
      for (int w = 0; w < 4; w++)
        win_row[w*REF_WORD_W +: REF_WORD_W] = ref_buf[{5'(row_q + 5'(r)), 2'(w)}];
      ref_blk[r*BLK*PIX_W +: BLK*PIX_W] = 64'(win_row >> {col_q, 3'b000});
    end
  end

  sad_8x8 u_sad (
    .cur_pix_i (cur_blk),
    .ref_pix_i (ref_blk),
    .sad_o     (sad)
  );

  assign last_cand = (row_q == OFF_LAST) && (col_q == OFF_LAST);

  always_comb begin
    best_sad_d = best_sad_q;
    best_row_d = best_row_q;
    best_col_d = best_col_q;
    if ((row_q == 5'd0 && col_q == 5'd0) || (sad < best_sad_q)) begin
      best_sad_d = sad;
      best_row_d = row_q;
      best_col_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      best_sad_q <= '0;
      best_row_q <= '0;
      best_col_q <= '0;
      cur_rd_q   <= 1'b0;
      ref_rd_q   <= 1'b0;
      valid_q    <= 1'b0;
      msad_q     <= '0;
      msad_row_q <= '0;
      msad_col_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en_i) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            cur_rd_q <= 1'b1;
          end
        end
        LOAD: begin
          cnt_q    <= cnt_q + 8'd1;
          cur_rd_q <= (cnt_q < CUR_LAST_STROBE);
          ref_rd_q <= (cnt_q >= CUR_LAST_STROBE) && (cnt_q < REF_LAST_STROBE);
          if (cnt_q == LOAD_LAST) begin
            state_q <= SEARCH;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        SEARCH: begin
          best_sad_q <= best_sad_d;
          best_row_q <= best_row_d;
          best_col_q <= best_col_d;
          if (col_q == OFF_LAST) begin
            col_q <= '0;
            row_q <= row_q + 5'd1;
          end else begin
            col_q <= col_q + 5'd1;
          end
          if (last_cand) begin
            state_q    <= DONE;
            valid_q    <= 1'b1;
            msad_q     <= best_sad_d;
            msad_row_q <= best_row_d;
            msad_col_q <= best_col_d;
          end
        end
        DONE: begin
          if (bus.en_i) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            cur_rd_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cur_read_en = cur_rd_q;
  assign bus.ref_read_en = ref_rd_q;
  assign bus.MSAD        = msad_q;
  assign bus.MSAD_row    = msad_row_q;
  assign bus.MSAD_column = msad_col_q;
  assign bus.data_valid  = valid_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_motion_estimator.sv
// Randomized bench for motion_estimator: streamer models, full-search reference model, cycle checks.
module tb_motion_estimator;
  import me_pkg::*;

  logic clk = 1'b0;
  logic rst;
  me_if bus ();

  motion_estimator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int          cur_px [8][8];
  int          ref_px [32][32];
  logic [31:0] cur_mem [16];
  logic [63:0] ref_mem [128];
  int          cur_ptr = 0;
  int          ref_ptr = 0;
  bit          cur_pend = 0;
  bit          ref_pend = 0;
  int          prev_msad = 0;
  int          prev_row = 0;
  int          prev_col = 0;

  // Streamers: a strobe seen in cycle N puts the next word on the bus in cycle N+1.
  always @(negedge clk) begin
    if (cur_pend) begin
      bus.cur_in_i = cur_mem[cur_ptr];
      cur_ptr = (cur_ptr + 1) % 16;
    end
    if (ref_pend) begin
      bus.ref_in_i = ref_mem[ref_ptr];
      ref_ptr = (ref_ptr + 1) % 128;
    end
    cur_pend = bus.cur_read_en;
    ref_pend = bus.ref_read_en;
  end

  task automatic pack_mems();
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++)
        cur_mem[i][k*8 +: 8] = 8'(cur_px[i/2][(i%2)*4 + k]);
    for (int j = 0; j < 128; j++)
      for (int k = 0; k < 8; k++)
        ref_mem[j][k*8 +: 8] = 8'(ref_px[j/4][(j%4)*8 + k]);
  endtask

  task automatic ref_model(output int ms, output int mr, output int mc);
    int s, d;
    ms = -1;
    mr = 0;
    mc = 0;
    for (int ro = 0; ro < 25; ro++)
      for (int co = 0; co < 25; co++) begin
        s = 0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            d = cur_px[r][c] - ref_px[ro + r][co + c];
            s += (d < 0) ? -d : d;
          end
        if (ms < 0 || s < ms) begin
          ms = s;
          mr = ro;
          mc = co;
        end
      end
  endtask

  task automatic fill(input int cur_v, input int ref_v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cur_px[r][c] = (cur_v < 0) ? int'($urandom_range(0, 255)) : cur_v;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) ref_px[r][c] = (ref_v < 0) ? int'($urandom_range(0, 255)) : ref_v;
  endtask

  // Runs one block: cycle 0 is the first LOAD cycle; en_i is cleared at drop_cyc (-1 = never).
  // chained=1 means the caller already sits at cycle 0 (back-to-back start).
  task automatic run_block(input string tag, input int drop_cyc, input bit chained);
    int ms, mr, mc;
    int strobe_err = 0;
    int dv_cnt = 0;
    int dv_cyc = -1;
    int idle_err = 0;
    bit en_at_done = 1'b0;
    pack_mems();
    ref_model(ms, mr, mc);
    if (!chained) begin
      @(negedge clk);
      bus.en_i = 1'b1;
    end
    for (int cyc = 0; cyc <= 771; cyc++) begin
      if (!(chained && cyc == 0)) @(negedge clk);
      if (cyc == drop_cyc) bus.en_i = 1'b0;
      if (cyc == 770) en_at_done = bus.en_i;
      if (cyc == 771) begin
        check($sformatf("%s_next_cur_rd", tag), int'(bus.cur_read_en), int'(en_at_done));
      end else begin
        if (bus.cur_read_en !== (cyc <= 15)) strobe_err++;
        if (bus.ref_read_en !== (cyc >= 16 && cyc <= 143)) strobe_err++;
        if (bus.data_valid === 1'b1) begin
          dv_cnt++;
          dv_cyc = cyc;
        end
        if (cyc == 500) begin
          check($sformatf("%s_hold_msad", tag), int'(bus.MSAD), prev_msad);
          check($sformatf("%s_hold_pos", tag), int'(bus.MSAD_row) * 32 + int'(bus.MSAD_column),
                prev_row * 32 + prev_col);
        end
        if (cyc == 770) begin
          check($sformatf("%s_msad", tag), int'(bus.MSAD), ms);
          check($sformatf("%s_row", tag), int'(bus.MSAD_row), mr);
          check($sformatf("%s_col", tag), int'(bus.MSAD_column), mc);
        end
      end
    end
    check($sformatf("%s_strobes", tag), strobe_err, 0);
    check($sformatf("%s_dv_count", tag), dv_cnt, 1);
    check($sformatf("%s_dv_cycle", tag), dv_cyc, 770);
    prev_msad = ms;
    prev_row  = mr;
    prev_col  = mc;
    if (!en_at_done) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bus.cur_read_en !== 1'b0 || bus.ref_read_en !== 1'b0 || bus.data_valid !== 1'b0) idle_err++;
      end
      check($sformatf("%s_idle_quiet", tag), idle_err, 0);
      check($sformatf("%s_idle_state", tag), int'(bus.dbg_state), int'(IDLE));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check($sformatf("%s_msad", tag), int'(bus.MSAD), 0);
    check($sformatf("%s_row", tag), int'(bus.MSAD_row), 0);
    check($sformatf("%s_col", tag), int'(bus.MSAD_column), 0);
    check($sformatf("%s_dv", tag), int'(bus.data_valid), 0);
    check($sformatf("%s_strobes", tag), int'(bus.cur_read_en) + int'(bus.ref_read_en), 0);
  endtask

  task automatic reset_mid_block();
    int quiet_err = 0;
    fill(-1, -1);
    pack_mems();
    @(negedge clk);
    bus.en_i = 1'b1;
    for (int cyc = 0; cyc <= 300; cyc++) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    bus.en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.data_valid !== 1'b0 || bus.cur_read_en !== 1'b0 || bus.ref_read_en !== 1'b0) quiet_err++;
    end
    check("rst_quiet", quiet_err, 0);
    cur_ptr = 0;
    ref_ptr = 0;
    prev_msad = 0;
    prev_row = 0;
    prev_col = 0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.en_i = 1'b0;
    bus.cur_in_i = '0;
    bus.ref_in_i = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_state", int'(bus.dbg_state), int'(IDLE));
    rst = 1'b1;

    fill(0, 0);
    run_block("zeros", 0, 1'b0);
    fill(10, 20);
    run_block("tie640", 0, 1'b0);
    fill(255, 0);
    run_block("max", -1, 1'b0);

    // Exact match planted at row 5, column 9 of a random window.
    fill(-1, -1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cur_px[r][c] = ref_px[5 + r][9 + c];
    run_block("patch", 400, 1'b1);

    for (int t = 0; t < 3; t++) begin
      fill(-1, -1);
      run_block($sformatf("rand%0d", t), int'($urandom_range(0, 770)), 1'b0);
    end

    reset_mid_block();
    fill(-1, -1);
    run_block("after_rst", 200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
